// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo family and its credit-based link helpers.
package fifo_pkg;

    // Credit counters hold 0..depth inclusive, so they need one extra code point.
    function automatic int unsigned credit_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_credit_cnt.sv
// Saturating up/down counter with synchronous load; flags increments attempted at MAX.
module fifo_credit_cnt
    import fifo_pkg::*;
#(
    parameter int unsigned MAX   = 8,
    parameter int unsigned WIDTH = credit_cnt_width(MAX)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] init_i,
    output logic [WIDTH-1:0] count_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    logic [WIDTH-1:0] count_q;

    // Load wins over inc/dec, so an overflowing increment during load is not an error.
    assign ovf_o   = inc_i && !dec_i && !load_i && (count_q == MAX_C);
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= MAX_C;
        end else if (load_i) begin
            count_q <= init_i;
        end else if (inc_i && !dec_i && (count_q != MAX_C)) begin
            count_q <= count_q + ONE_C;
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_q <= count_q - ONE_C;
        end
    end

endmodule

// File: rtl/fifo_credit_tx.sv
// Transmit end of a credit link: pushes into a remote FIFO only while holding a credit.
module fifo_credit_tx
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned LOW_CREDIT_TH = 1,
    parameter type         dtype         = logic [DATA_WIDTH-1:0],
    parameter int unsigned CNT_WIDTH     = credit_cnt_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  dtype                 data_i,
    output logic                 push_o,
    output dtype                 data_o,
    input  logic                 credit_i,
    output logic [CNT_WIDTH-1:0] credits_o,
    output logic                 no_credit_o,
    output logic                 low_credit_o,
    output logic                 err_o
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    if (DEPTH == 0) begin : g_bad_depth
        $error("fifo_credit_tx: DEPTH must be >= 1");
    end

    logic [CNT_WIDTH-1:0] credits;
    logic                 accept;
    logic                 ovf;
    logic                 push_q;
    dtype                 data_q;
    logic                 err_q;

    // Ready never looks at valid_i, keeping the upstream handshake loop-free.
    assign ready_o = (credits != '0) && !flush_i;
    assign accept  = valid_i && ready_o;

    fifo_credit_cnt #(
        .MAX   (DEPTH),
        .WIDTH (CNT_WIDTH)
    ) u_credit_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (credit_i),
        .dec_i   (accept),
        .load_i  (flush_i),
        .init_i  (DEPTH_C),
        .count_o (credits),
        .ovf_o   (ovf)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            push_q <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            push_q <= accept;
            if (accept) begin
                data_q <= data_i;
            end
            if (ovf) begin
                err_q <= 1'b1;
            end
        end
    end

    assign push_o       = push_q;
    assign data_o       = data_q;
    assign err_o        = err_q;
    assign credits_o    = credits;
    assign no_credit_o  = (credits == '0);
    assign low_credit_o = (32'(credits) <= LOW_CREDIT_TH);

`ifndef SYNTHESIS
    a_credits_bounded : assert property (
        @(posedge clk_i) disable iff (!rst_ni) credits <= DEPTH_C
    ) else $error("fifo_credit_tx: credit count exceeds DEPTH");

    a_no_push_without_credit : assert property (
        @(posedge clk_i) disable iff (!rst_ni) (credits == '0) |=> !push_o
    ) else $error("fifo_credit_tx: push issued without a credit");

    a_upstream_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> (valid_i && $stable(data_i))
    ) else $warning("fifo_credit_tx: upstream dropped or changed a stalled beat");
`endif

endmodule

// File: tb/tb_fifo_credit_tx.sv
// Directed bench for fifo_credit_tx with a push-data scoreboard and direct status checks.
module tb_fifo_credit_tx;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          valid;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic          push_o;
    logic [DW-1:0] data_o;
    logic          credit;
    logic [CW-1:0] credits_o;
    logic          no_credit_o;
    logic          low_credit_o;
    logic          err_o;

    int            vectors = 0;
    int            misc    = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_credit_tx #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .LOW_CREDIT_TH (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .valid_i      (valid),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .push_o       (push_o),
        .data_o       (data_o),
        .credit_i     (credit),
        .credits_o    (credits_o),
        .no_credit_o  (no_credit_o),
        .low_credit_o (low_credit_o),
        .err_o        (err_o)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            misc++;
            $display("FAIL %s got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every push must match the next expected beat.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && push_o === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                misc++;
                $display("FAIL push_unexpected got data_o=%0h required no push", data_o);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    misc++;
                    $display("FAIL push_data got %0h required %0h", data_o, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        valid  = 1'b0;
        credit = 1'b0;
        data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_credits", credits_o, DEPTH);
        chk("rst_push", push_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ready", ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Drain all credits with a continuous stream 1..9.
        valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            data_i = i;
            #1;
            chk("drain_credits", credits_o, 9 - i);
            chk("drain_ready", ready_o, (i <= 8));
            chk("drain_low", low_credit_o, ((9 - i) <= 2));
            if (i <= 8) exp_q.push_back(i);
            step();
        end
        chk("empty_credits", credits_o, 0);
        chk("empty_no_credit", no_credit_o, 1);
        chk("empty_ready", ready_o, 0);

        // Single credit at zero: no same-cycle bypass.
        credit = 1'b1;
        #1;
        chk("zero_credit_ready", ready_o, 0);
        step();
        credit = 1'b0;
        #1;
        chk("one_credit_count", credits_o, 1);
        chk("one_credit_ready", ready_o, 1);
        exp_q.push_back(32'h9);
        step();
        valid = 1'b0;
        chk("one_credit_push", push_o, 1);
        chk("one_credit_back", credits_o, 0);

        // Build up to 3 credits, then stream with credit returns every cycle.
        credit = 1'b1;
        repeat (3) step();
        credit = 1'b0;
        #1;
        chk("steady_start", credits_o, 3);
        for (int k = 0; k < 20; k++) begin
            valid  = 1'b1;
            credit = 1'b1;
            data_i = 32'h100 + k;
            #1;
            chk("steady_credits", credits_o, 3);
            exp_q.push_back(32'h100 + k);
            step();
        end
        valid  = 1'b0;
        credit = 1'b0;
        #1;
        chk("steady_end", credits_o, 3);

        // Fill to DEPTH, then overflow.
        credit = 1'b1;
        repeat (5) step();
        credit = 1'b0;
        #1;
        chk("full_credits", credits_o, 8);
        chk("full_err", err_o, 0);
        credit = 1'b1;
        step();
        credit = 1'b0;
        #1;
        chk("ovf_credits", credits_o, 8);
        chk("ovf_err", err_o, 1);

        // Drain to 2, then flush together with a credit return.
        valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data_i = 32'h200 + k;
            exp_q.push_back(32'h200 + k);
            step();
        end
        chk("pre_flush_credits", credits_o, 2);
        flush  = 1'b1;
        credit = 1'b1;
        #1;
        chk("flush_ready", ready_o, 0);
        step();
        flush  = 1'b0;
        credit = 1'b0;
        valid  = 1'b0;
        #1;
        chk("flush_no_push", push_o, 0);
        chk("flush_credits", credits_o, 8);
        chk("flush_low", low_credit_o, 0);
        chk("flush_err_kept", err_o, 1);

        // Low-credit threshold on drain and recovery.
        valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data_i = 32'h300 + k;
            #1;
            chk("low_drain", low_credit_o, ((8 - k) <= 2));
            exp_q.push_back(32'h300 + k);
            step();
        end
        valid = 1'b0;
        #1;
        chk("low_at_2", low_credit_o, 1);
        credit = 1'b1;
        step();
        credit = 1'b0;
        #1;
        chk("low_back_3_count", credits_o, 3);
        chk("low_back_3", low_credit_o, 0);

        // Reset while a push is on the wire drops it immediately.
        step();
        valid  = 1'b1;
        data_i = 32'hABC;
        step();
        valid = 1'b0;
        chk("mid_push_high", push_o, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_push", push_o, 0);
        chk("mid_rst_credits", credits_o, 8);
        chk("mid_rst_err", err_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
